// File: rtl/spi_accel_pkg.sv
// Shared constants and state encoding for the SPI accelerometer responder.
package spi_accel_pkg;

    localparam int SAMPLE_W = 12;

    // Command bytes
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    // Register map
    localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
    localparam logic [7:0] ADDR_PARTID    = 8'h02;
    localparam logic [7:0] ADDR_XDATA     = 8'h08;
    localparam logic [7:0] ADDR_YDATA     = 8'h09;
    localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
    localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
    localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } spi_state_t;

endpackage

// File: rtl/spi_accel_responder_edge_sync.sv
// spi_edge_sync: 2-FF synchronizer for an asynchronous SPI pin, plus
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchronizer plus one history stage for edge detection.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 slave emulating an ADXL362-style register
// interface. Serves ID, sample and POWER_CTL registers from CLK-domain data.
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                sclk_i,
    input  logic                ss_i,
    input  logic                mosi_i,
    output logic                miso_o,
    input  logic [SAMPLE_W-1:0] x_data,
    input  logic [SAMPLE_W-1:0] y_data,
    input  logic [SAMPLE_W-1:0] z_data,
    output logic [7:0]          power_ctl,
    output logic                wr_pulse,
    output logic                busy
);

    spi_state_t          state_q, state_d;
    logic                sclk_rise, sclk_fall, sclk_lvl_unused;
    logic                ss_sync, ss_fall, ss_rise_unused;
    logic                mosi_meta_q, mosi_sync_q;
    logic [2:0]          bit_cnt_q;
    logic [6:0]          rx_sr_q;
    logic [6:0]          tx_sr_q;
    logic [7:0]          addr_q;
    logic                is_read_q;
    logic [SAMPLE_W-1:0] x_sh_q, y_sh_q, z_sh_q;
    logic [7:0]          rx_byte;
    logic [7:0]          rd_byte;
    logic                byte_done;

    // SCLK only matters through its edges.
    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .CLK     (CLK),
        .rst     (rst),
        .async_i (sclk_i),
        .sync_o  (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // SS resets to "selected" so a frame already running at reset release
    // never produces a falling edge; only a fresh high->low starts a frame.
    spi_edge_sync #(.RST_VAL(1'b0)) u_ss_sync (
        .CLK     (CLK),
        .rst     (rst),
        .async_i (ss_i),
        .sync_o  (ss_sync),
        .rise_o  (ss_rise_unused),
        .fall_o  (ss_fall)
    );

    // MOSI synchronizer, same depth as SCLK so data and edge stay aligned.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Register read mux over the frame's shadow samples.
    function automatic logic [7:0] reg_rd(
        input logic [7:0]          a,
        input logic [SAMPLE_W-1:0] xs,
        input logic [SAMPLE_W-1:0] ys,
        input logic [SAMPLE_W-1:0] zs,
        input logic [7:0]          pc
    );
        case (a)
            ADDR_DEVID_AD:  reg_rd = DEVID_AD;
            ADDR_DEVID_MST: reg_rd = DEVID_MST;
            ADDR_PARTID:    reg_rd = PARTID;
            ADDR_XDATA:     reg_rd = xs[11:4];
            ADDR_YDATA:     reg_rd = ys[11:4];
            ADDR_ZDATA:     reg_rd = zs[11:4];
            ADDR_XDATA_L:   reg_rd = xs[7:0];
            ADDR_XDATA_H:   reg_rd = {{4{xs[11]}}, xs[11:8]};
            ADDR_YDATA_L:   reg_rd = ys[7:0];
            ADDR_YDATA_H:   reg_rd = {{4{ys[11]}}, ys[11:8]};
            ADDR_ZDATA_L:   reg_rd = zs[7:0];
            ADDR_ZDATA_H:   reg_rd = {{4{zs[11]}}, zs[11:8]};
            ADDR_POWER_CTL: reg_rd = pc;
            default:        reg_rd = 8'h00;
        endcase
    endfunction

    assign rx_byte   = {rx_sr_q, mosi_sync_q};
    assign byte_done = sclk_rise && !ss_sync && (bit_cnt_q == 3'd7);
    assign rd_byte   = reg_rd(addr_q, x_sh_q, y_sh_q, z_sh_q, power_ctl);
    assign busy      = (state_q != ST_IDLE);

    // FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: frame phases advance on completed bytes; SS high always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ss_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) state_d = ST_ADDR;
                    else                                             state_d = ST_IGNORE;
                end
            end
            ST_ADDR: if (byte_done) state_d = ST_DATA;
            default: state_d = state_q;
        endcase
        if (ss_sync) state_d = ST_IDLE;
    end

    // Shift/datapath: RX shifting on rising edges, TX shifting on falling
    // edges, address auto-increment, register write and sample snapshot.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 7'd0;
            tx_sr_q   <= 7'd0;
            addr_q    <= 8'h00;
            is_read_q <= 1'b0;
            miso_o    <= 1'b0;
            power_ctl <= 8'h00;
            wr_pulse  <= 1'b0;
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            z_sh_q    <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (state_q == ST_IDLE || ss_sync) begin
                // Out of frame: drop any partial byte and keep MISO quiet.
                bit_cnt_q <= 3'd0;
                miso_o    <= 1'b0;
                if (state_q == ST_IDLE && ss_fall) begin
                    x_sh_q <= x_data;
                    y_sh_q <= y_data;
                    z_sh_q <= z_data;
                end
            end else begin
                if (sclk_rise) begin
                    rx_sr_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_CMD:  is_read_q <= (rx_byte == CMD_READ);
                            ST_ADDR: addr_q    <= rx_byte;
                            ST_DATA: begin
                                addr_q <= addr_q + 8'd1;
                                if (!is_read_q) begin
                                    wr_pulse <= 1'b1;
                                    if (addr_q == ADDR_POWER_CTL) power_ctl <= rx_byte;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (sclk_fall) begin
                    if (state_q == ST_DATA && is_read_q) begin
                        // Byte boundary: look up and present bit 7 in one go.
                        if (bit_cnt_q == 3'd0) begin
                            miso_o  <= rd_byte[7];
                            tx_sr_q <= rd_byte[6:0];
                        end else begin
                            miso_o  <= tx_sr_q[6];
                            tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                        end
                    end else begin
                        miso_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Testbench for spi_accel_responder: directed frames plus randomized frames,
// checked against a byte-level register-map model of the sensor.
module tb_spi_accel_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso_o;
    logic [11:0] x_data = '0, y_data = '0, z_data = '0;
    logic [7:0]  power_ctl;
    logic        wr_pulse;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_seen = 0;
    int          hp      = 100;        // SCLK half period (CLK = 10)
    int          chg_byte = -1;        // byte index at which x_data changes
    logic [11:0] chg_x   = '0;
    logic [7:0]  model_pc = 8'h00;
    logic [7:0]  mmap [256];
    logic [7:0]  tx [16];
    logic [7:0]  rx [16];

    spi_accel_responder dut (
        .CLK       (clk),
        .rst       (rst),
        .sclk_i    (sclk),
        .ss_i      (ss),
        .mosi_i    (mosi),
        .miso_o    (miso_o),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .power_ctl (power_ctl),
        .wr_pulse  (wr_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse) wr_seen = wr_seen + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sensor register map as seen at frame start.
    task automatic build_map();
        int v [3];
        v[0] = int'(x_data); v[1] = int'(y_data); v[2] = int'(z_data);
        for (int a = 0; a < 256; a++) mmap[a] = 8'h00;
        mmap[0] = 8'hAD; mmap[1] = 8'h1D; mmap[2] = 8'hF2;
        for (int i = 0; i < 3; i++) begin
            mmap[8 + i]      = 8'(v[i] / 16);
            mmap[14 + 2 * i] = 8'(v[i] % 256);
            mmap[15 + 2 * i] = 8'(v[i] / 256 + (v[i] >= 2048 ? 240 : 0));
        end
        mmap[8'h2D] = model_pc;
    endtask

    // Bit-bang one mode-0 frame; MISO is sampled just before each rising edge.
    task automatic spi_xfer(input int nbits, input int rst_bit);
        ss = 1'b0;
        #100;
        chk("busy_on", busy, 1);
        for (int b = 0; b < nbits; b++) begin
            int byi = b / 8;
            int bi  = 7 - (b % 8);
            if (b == rst_bit) begin
                rst = 1'b1;
                #30;
                chk("rst_miso", miso_o, 0);
                chk("rst_pc", power_ctl, 0);
                rst = 1'b0;
            end
            if (b % 8 == 0 && byi == chg_byte) x_data = chg_x;
            mosi = tx[byi][bi];
            #(hp);
            rx[byi][bi] = miso_o;
            sclk = 1'b1;
            #(hp);
            sclk = 1'b0;
        end
        #(hp);
        ss = 1'b1;
        #100;
        chk("busy_off", busy, 0);
        chk("miso_idle", miso_o, 0);
    endtask

    // Run a frame and check every full byte of MISO, write strobes and POWER_CTL.
    task automatic do_frame(input int nbits, input int rst_bit);
        int   wr0 = wr_seen;
        int   nfull = nbits / 8;
        int   exp_wr = 0;
        logic [7:0] exp_rx [16];
        build_map();
        for (int k = 0; k < 16; k++) exp_rx[k] = 8'h00;
        if (rst_bit >= 0) begin
            model_pc = 8'h00;
        end else begin
            for (int k = 2; k < nfull; k++) begin
                logic [7:0] a = 8'(int'(tx[1]) + k - 2);
                if (tx[0] == 8'h0B) exp_rx[k] = mmap[a];
                if (tx[0] == 8'h0A) begin
                    exp_wr++;
                    if (a == 8'h2D) model_pc = tx[k];
                end
            end
        end
        spi_xfer(nbits, rst_bit);
        for (int k = 0; k < nfull; k++) chk($sformatf("rx%0d cmd %0h", k, tx[0]), rx[k], exp_rx[k]);
        chk("wr_cnt", wr_seen - wr0, exp_wr);
        chk("power_ctl", power_ctl, model_pc);
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3);
        for (int k = 0; k < 16; k++) tx[k] = 8'h00;
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
    endtask

    initial begin
        logic [7:0] pick [14];
        pick = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A, 8'h0E,
                 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h2D, 8'hFE};
        #2;
        #50;
        chk("rst_miso", miso_o, 0);
        chk("rst_power_ctl", power_ctl, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #100;

        // ID read at 5 MHz
        hp = 100;
        set_tx(8'h0B, 8'h00, 8'h00, 8'h00);
        do_frame(40, -1);
        chk("id_ad", rx[2], 8'hAD);

        // Coherent 12-bit read with x changing mid-frame
        x_data = 12'h823; y_data = 12'h7FF; z_data = 12'h001;
        set_tx(8'h0B, 8'h0E, 8'h00, 8'h00);
        chg_byte = 4; chg_x = 12'h000;
        do_frame(64, -1);
        chg_byte = -1;
        chk("coh_xh", rx[3], 8'hF8);

        // Writes: POWER_CTL, then a read-only address, then read back
        set_tx(8'h0A, 8'h2D, 8'h02, 8'h00);
        do_frame(24, -1);
        set_tx(8'h0A, 8'h00, 8'h55, 8'h00);
        do_frame(24, -1);
        set_tx(8'h0B, 8'h00, 8'h00, 8'h00);
        do_frame(40, -1);
        set_tx(8'h0B, 8'h2D, 8'h00, 8'h00);
        do_frame(24, -1);
        chk("pc_readback", rx[2], 8'h02);

        // Address wrap and unmapped read
        set_tx(8'h0B, 8'hFF, 8'h00, 8'h00);
        do_frame(32, -1);

        // Unknown command
        set_tx(8'h0C, 8'h2D, 8'h12, 8'h34);
        do_frame(32, -1);

        // Abort after 4 address bits, then a clean read
        set_tx(8'h0B, 8'h01, 8'h00, 8'h00);
        do_frame(12, -1);
        do_frame(24, -1);

        // Reset in the middle of a write frame
        set_tx(8'h0A, 8'h2D, 8'h07, 8'h07);
        do_frame(32, 12);
        set_tx(8'h0B, 8'h2D, 8'h00, 8'h00);
        do_frame(24, -1);

        // Randomized frames at 10 MHz
        hp = 50;
        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 9);
            int n = $urandom_range(1, 5);
            int nb;
            x_data = 12'($urandom); y_data = 12'($urandom); z_data = 12'($urandom);
            for (int k = 0; k < 16; k++) tx[k] = 8'($urandom);
            if (r < 5)      tx[0] = 8'h0B;
            else if (r < 8) tx[0] = 8'h0A;
            else if (tx[0] == 8'h0A || tx[0] == 8'h0B) tx[0] = 8'h00;
            if ($urandom_range(0, 1) == 0) tx[1] = pick[$urandom_range(0, 13)];
            nb = 8 * (2 + n);
            if ($urandom_range(0, 3) == 0) nb = nb + $urandom_range(1, 7);
            do_frame(nb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI slave that emulates the ADXL362-style accelerometer register interface on the far end of the player's SPI link. It answers register read and write commands from the game's SPI master (SS/SCLK/MOSI/MISO) using system-supplied X/Y/Z sample values. It lets the player/tilt path be simulated and bench-tested without the physical sensor, and it can also drive a second board as a stand-in sensor. It sits outside `top`, wired pin-for-pin to the master's SS, SCLK, SDO (MOSI) and SDI (MISO).

## Interface
Parameters:
- `DEVID_AD`, 8'hAD, value returned at address 0x00
- `DEVID_MST`, 8'h1D, value returned at address 0x01
- `PARTID`, 8'hF2, value returned at address 0x02

Ports:
- `CLK` in 1: system clock, 100 MHz
- `rst` in 1: asynchronous, active-high reset
- `sclk_i` in 1: SPI clock from master, asynchronous to CLK
- `ss_i` in 1: slave select, active low, asynchronous
- `mosi_i` in 1: master-out data, asynchronous
- `miso_o` out 1: master-in data
- `x_data`, `y_data`, `z_data` in 12 each: signed samples, CLK domain
- `power_ctl` out 8: POWER_CTL register contents
- `wr_pulse` out 1: one-CLK strobe per accepted register write
- `busy` out 1: high while a frame is in progress (synchronized SS low)

## Operation
- Protocol: SPI mode 0, MSB first. Frame = SS low, command byte, address byte, then N data bytes. Frame ends when SS goes high.
- Commands:
  - 0x0B = read.
  - 0x0A = write.
  - Any other command → IGNORE state; `miso_o`=0 until SS high.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE→CMD on synchronized SS falling.
  - CMD→ADDR after 8 bits.
  - ADDR→DATA after 8 bits.
  - DATA stays in DATA, one byte per 8 bits.
  - SS rising returns to IDLE from any state, discarding any partial byte.
- Address auto-increments after each data byte and wraps 0xFF→0x00.
- Register map (reads):
  - 0x00–0x02: ID parameters.
  - 0x08 = x[11:4], 0x09 = y[11:4], 0x0A = z[11:4].
  - 0x0E = x[7:0], 0x0F = {4×x[11], x[11:8]}; Y at 0x10/0x11; Z at 0x12/0x13.
  - 0x2D = `power_ctl`.
  - All other addresses read 0x00.
- Writes:
  - Only 0x2D is writable; it loads `power_ctl` on the 8th data bit.
  - `wr_pulse` asserts for every complete write data byte, including bytes to read-only addresses, which are otherwise ignored.
- Snapshot: X/Y/Z are captured into shadow registers on the CLK cycle the SS falling edge is detected, so multi-byte reads within one frame are coherent.
- `miso_o` = 0 whenever SS is high, in CMD/ADDR/IGNORE, and during write frames.
- Reset values: `miso_o`=0, `power_ctl`=0x00, `wr_pulse`=0, `busy`=0, FSM=IDLE, bit counter=0.
- Reset asserted mid-frame aborts the frame immediately. After reset release, the responder waits for a fresh SS falling edge; it does not resynchronize into a frame already in progress.

## Timing
- `sclk_i`, `ss_i` and `mosi_i` each pass through a 2-FF synchronizer; edges are detected on the synchronized SCLK.
- Supported SCLK ≤ CLK/8 (12.5 MHz). Minimum SS-low to first SCLK rising edge: 4 CLK.
- MOSI is sampled on the detected SCLK rising edge, using the synchronized MOSI of that same cycle.
- MISO shifts on the detected SCLK falling edge. `miso_o` is registered and valid ≤3 CLK after the physical falling edge.
- Read data bit 7 appears after the falling edge that follows address bit 0. Each following byte's bit 7 appears after the falling edge that follows the previous byte's bit 0.
- Byte lookup (address → shift register) completes in the same CLK cycle as the load.
- `busy` rises 2–3 CLK after physical SS falls and drops 2–3 CLK after SS rises.
- `wr_pulse` fires 1 CLK after the rising edge that samples the 8th write data bit. `power_ctl` updates on that same cycle.

## Structure
- Shared package `spi_accel_pkg` holds:
  - command constants CMD_READ=0x0B and CMD_WRITE=0x0A;
  - register address constants;
  - the state enum.
- Sub-module `spi_edge_sync`: 2-FF synchronizer plus rise/fall pulse generation, instantiated once each for SCLK and SS; MOSI uses the synchronizer only.
- The register mux is a combinational function of address, shadow samples and `power_ctl`, kept inside the responder.

## Test plan
- Read ID: frame 0x0B,0x00, then 3 dummy bytes at SCLK=5 MHz → MISO bytes 0xAD,0x1D,0xF2; `busy` high for the frame only.
- Coherent 12-bit read: x=0x823, y=0x7FF, z=0x001; read from 0x0E for 6 bytes, changing x to 0x000 mid-frame → 0x23,0xF8,0xFF,0x07,0x01,0x00.
- Write: 0x0A,0x2D,0x02 → `power_ctl`=0x02 and one `wr_pulse`. Then 0x0A,0x00,0x55 → one `wr_pulse`, IDs unchanged; a read of 0x2D returns 0x02.
- Wrap and unmapped: read from 0xFF for 2 bytes → 0x00,0xAD. Bad command 0x0C → MISO 0 for the whole frame, no `wr_pulse`.
- Abort: SS high after 4 address bits, then a clean read of 0x01 → 0x1D. Assert `rst` mid-write frame → `power_ctl`=0x00 and `miso_o`=0; the remainder of that frame is ignored.
